// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: serves requests in the current travel direction before
// reversing, with door timing, per-floor travel timing and an emergency stop.
module elevator_scan_ctrl #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned TRAVEL_CYCLES = 2,
  localparam int unsigned FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  emergency_stop,
  input  logic [NUM_FLOORS-1:0] floor_request,
  output logic [2:0]            state,
  output logic [FW-1:0]         current_floor,
  output logic                  door_open,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_DOOR  = 3'd3,
    S_ESTOP = 3'd4
  } state_t;

  state_t                cur_state, nxt_state;
  logic [FW-1:0]         floor_q, nxt_floor;
  logic                  dir_q, nxt_dir;
  logic                  door_q, nxt_door;
  logic [NUM_FLOORS-1:0] pend_q, nxt_pend;
  logic [TW-1:0]         tcnt_q, nxt_tcnt;
  logic [DW-1:0]         dcnt_q, nxt_dcnt;

  logic [NUM_FLOORS-1:0] req_eff;
  logic [NUM_FLOORS-1:0] beyond;
  logic [FW-1:0]         step_floor;
  logic                  at_end;

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < int'(NUM_FLOORS); i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < int'(NUM_FLOORS); i++) m[i] = (i < int'(f));
    return m;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      pend_q    <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      cur_state <= nxt_state;
      floor_q   <= nxt_floor;
      dir_q     <= nxt_dir;
      door_q    <= nxt_door;
      pend_q    <= nxt_pend;
      tcnt_q    <= nxt_tcnt;
      dcnt_q    <= nxt_dcnt;
    end
  end

  // Next-state, request latching and counter control
  always_comb begin
    req_eff    = pend_q | floor_request;
    step_floor = (cur_state == S_DOWN) ? floor_q - FW'(1) : floor_q + FW'(1);
    beyond     = (cur_state == S_DOWN) ? below_mask(step_floor) : above_mask(step_floor);
    at_end     = (cur_state == S_DOWN) ? (floor_q == '0) : (floor_q == FW'(NUM_FLOORS - 1));

    nxt_state = cur_state;
    nxt_floor = floor_q;
    nxt_dir   = dir_q;
    nxt_pend  = req_eff;
    nxt_tcnt  = tcnt_q;
    nxt_dcnt  = dcnt_q;

    if (emergency_stop) begin
      nxt_state = S_ESTOP;
      nxt_pend  = '0;
      nxt_tcnt  = '0;
      nxt_dcnt  = '0;
    end else begin
      unique case (cur_state)
        S_IDLE: begin
          nxt_tcnt = '0;
          nxt_dcnt = '0;
          if (req_eff[floor_q]) begin
            nxt_state         = S_DOOR;
            nxt_pend[floor_q] = 1'b0;
          end else if (dir_q && |(req_eff & above_mask(floor_q))) begin
            nxt_state = S_UP;
          end else if (|(req_eff & below_mask(floor_q))) begin
            nxt_state = S_DOWN;
            nxt_dir   = 1'b0;
          end else if (|(req_eff & above_mask(floor_q))) begin
            nxt_state = S_UP;
            nxt_dir   = 1'b1;
          end
        end
        S_UP, S_DOWN: begin
          if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
            nxt_tcnt = '0;
            // Never step past an end floor, even if state were corrupted
            if (at_end) begin
              nxt_state = S_IDLE;
            end else begin
              nxt_floor = step_floor;
              if (req_eff[step_floor]) begin
                nxt_state            = S_DOOR;
                nxt_pend[step_floor] = 1'b0;
                nxt_dcnt             = '0;
              end else if (!(|(req_eff & beyond))) begin
                nxt_state = S_IDLE;
              end
            end
          end else begin
            nxt_tcnt = tcnt_q + TW'(1);
          end
        end
        S_DOOR: begin
          if (floor_request[floor_q]) begin
            nxt_pend[floor_q] = 1'b0;
            nxt_dcnt          = '0;
          end else if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
            nxt_state = S_IDLE;
            nxt_dcnt  = '0;
          end else begin
            nxt_dcnt = dcnt_q + DW'(1);
          end
        end
        S_ESTOP: begin
          nxt_state = S_IDLE;
          nxt_pend  = '0;
          nxt_tcnt  = '0;
          nxt_dcnt  = '0;
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_pend  = '0;
          nxt_tcnt  = '0;
          nxt_dcnt  = '0;
        end
      endcase
    end

    nxt_door = (nxt_state == S_DOOR);
  end

  assign state         = cur_state;
  assign current_floor = floor_q;
  assign door_open     = door_q;
  assign direction     = dir_q;
  assign pending       = pend_q;

endmodule
